// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: round-robin, burst-bounded sharing of one 32-bit S-box between encipher and key expansion; define AES_SBOX_ARB_PIPE_EN to register the result (ack latency 1).
module aes_sbox_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_req,
  input  logic        enc_lock,
  input  logic [31:0] enc_sboxw,
  output logic        enc_ack,
  output logic [31:0] enc_new_sboxw,
  input  logic        key_req,
  input  logic        key_lock,
  input  logic [31:0] key_sboxw,
  output logic        key_ack,
  output logic [31:0] key_new_sboxw,
  output logic [31:0] sboxw,
  input  logic [31:0] new_sboxw,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, GNT_ENC, GNT_KEY} state_t;
  state_t     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       last_key_q, last_key_d;
  logic       own_key, own_req, own_lock, oth_req, acc, acc_enc, acc_key, burst_end;
  always_comb begin
    own_key    = state_q == GNT_KEY;
    own_req    = own_key ? key_req : enc_req;
    own_lock   = own_key ? key_lock : enc_lock;
    oth_req    = own_key ? enc_req : key_req;
    acc_enc    = state_q == GNT_ENC && enc_req;
    acc_key    = state_q == GNT_KEY && key_req;
    acc        = acc_enc | acc_key;
    burst_end  = acc && ({1'b0, burst_q} + 5'd1 >= 5'(MAX_BURST));
    sboxw      = state_q == GNT_ENC ? enc_sboxw : state_q == GNT_KEY ? key_sboxw : 32'h0;
    busy       = state_q != IDLE;
    state_d    = state_q;
    burst_d    = burst_q;
    last_key_d = last_key_q;
    if (state_q == IDLE)
      state_d = enc_req && key_req ? (last_key_q ? GNT_ENC : GNT_KEY) :
                enc_req ? GNT_ENC : key_req ? GNT_KEY : IDLE;
    else if (!own_lock && (!own_req || (burst_end && oth_req))) begin
      state_d    = oth_req ? (own_key ? GNT_ENC : GNT_KEY) : IDLE;
      burst_d    = '0;
      last_key_d = own_key;
    end else if (acc && burst_q != 4'hf)
      burst_d = burst_q + 4'd1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      last_key_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      last_key_q <= last_key_d;
    end
`ifdef AES_SBOX_ARB_PIPE_EN
  logic [31:0] res_q, res_d;
  logic        vld_q, vld_d, tag_key_q, tag_key_d;
  always_comb begin
    res_d         = acc ? new_sboxw : '0;
    vld_d         = acc;
    tag_key_d     = acc_key;
    enc_ack       = vld_q && !tag_key_q;
    key_ack       = vld_q && tag_key_q;
    enc_new_sboxw = enc_ack ? res_q : '0;
    key_new_sboxw = key_ack ? res_q : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      res_q     <= '0;
      vld_q     <= 1'b0;
      tag_key_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      vld_q     <= vld_d;
      tag_key_q <= tag_key_d;
    end
`else
  always_comb begin
    enc_ack       = acc_enc;
    key_ack       = acc_key;
    enc_new_sboxw = acc_enc ? new_sboxw : '0;
    key_new_sboxw = acc_key ? new_sboxw : '0;
  end
`endif
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb_aes_sbox_arbiter: directed stimulus, AES S-box environment and a behavioural arbiter model checked every cycle.
module tb_aes_sbox_arbiter;
  localparam int MAXB = 4;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic        clk = 0, reset_n = 0;
  logic        enc_req = 0, enc_lock = 0, key_req = 0, key_lock = 0;
  logic [31:0] enc_sboxw = 0, key_sboxw = 0;
  logic [31:0] new_sboxw, sboxw, enc_new_sboxw, key_new_sboxw;
  logic        enc_ack, key_ack, busy;
  int          total = 0, passed = 0;
  int          ack_log[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] sub(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      int b;
      b = int'(w[8*i +: 8]);
      r[8*i +: 8] = SBOX[2047 - 8*b -: 8];
    end
    return r;
  endfunction
  assign new_sboxw = sub(sboxw);
  aes_sbox_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n),
    .enc_req(enc_req), .enc_lock(enc_lock), .enc_sboxw(enc_sboxw),
    .enc_ack(enc_ack), .enc_new_sboxw(enc_new_sboxw),
    .key_req(key_req), .key_lock(key_lock), .key_sboxw(key_sboxw),
    .key_ack(key_ack), .key_new_sboxw(key_new_sboxw),
    .sboxw(sboxw), .new_sboxw(new_sboxw), .busy(busy));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // Model: owner 0 = nobody, 1 = encipher, 2 = key expansion; m_cnt = words acked in this grant.
  int          m_own = 0, m_cnt = 0, m_last = 2;
  logic        p_e = 0, p_k = 0;
  logic [31:0] p_ed = 0, p_kd = 0;
  int          own, n_own, n_cnt, n_last;
  logic        mr, ml, orq, e_ea, e_ka, x_ea, x_ka, n_pe, n_pk;
  logic [31:0] e_sboxw, x_ed, x_kd, n_ped, n_pkd;
  always_comb begin
    own     = reset_n ? m_own : 0;
    e_ea    = own == 1 && enc_req;
    e_ka    = own == 2 && key_req;
    e_sboxw = own == 1 ? enc_sboxw : own == 2 ? key_sboxw : 32'h0;
`ifdef AES_SBOX_ARB_PIPE_EN
    x_ea    = reset_n && p_e;
    x_ka    = reset_n && p_k;
    x_ed    = x_ea ? p_ed : 32'h0;
    x_kd    = x_ka ? p_kd : 32'h0;
`else
    x_ea    = e_ea;
    x_ka    = e_ka;
    x_ed    = e_ea ? sub(enc_sboxw) : 32'h0;
    x_kd    = e_ka ? sub(key_sboxw) : 32'h0;
`endif
    n_pe    = e_ea;
    n_pk    = e_ka;
    n_ped   = sub(enc_sboxw);
    n_pkd   = sub(key_sboxw);
    mr      = own == 1 ? enc_req : key_req;
    ml      = own == 1 ? enc_lock : key_lock;
    orq     = own == 1 ? key_req : enc_req;
    n_own   = own;
    n_cnt   = m_cnt;
    n_last  = m_last;
    if (own == 0)
      n_own = enc_req && key_req ? 3 - m_last : enc_req ? 1 : key_req ? 2 : 0;
    else if (!ml && (!mr || (orq && m_cnt + 1 >= MAXB))) begin
      n_own  = orq ? 3 - own : 0;
      n_cnt  = 0;
      n_last = own;
    end else if (mr)
      n_cnt = m_cnt + 1;
  end
  always @(negedge clk) begin
    chk("enc_ack", enc_ack, x_ea);
    chk("key_ack", key_ack, x_ka);
    chk("enc_new_sboxw", enc_new_sboxw, x_ed);
    chk("key_new_sboxw", key_new_sboxw, x_kd);
    chk("sboxw", sboxw, e_sboxw);
    chk("busy", busy, own != 0);
    chk("both_acks", enc_ack & key_ack, 0);
    if (enc_ack) ack_log.push_back(1);
    if (key_ack) ack_log.push_back(2);
    m_own  <= reset_n ? n_own : 0;
    m_cnt  <= reset_n ? n_cnt : 0;
    m_last <= reset_n ? n_last : 2;
    p_e    <= reset_n && n_pe;
    p_k    <= reset_n && n_pk;
    p_ed   <= reset_n ? n_ped : 32'h0;
    p_kd   <= reset_n ? n_pkd : 32'h0;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0;
    {enc_req, enc_lock, key_req, key_lock} = '0;
    enc_sboxw = 0;
    key_sboxw = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sboxw", sboxw, 0);
    chk("rst_acks", {enc_ack, key_ack}, 0);
    chk("rst_new", enc_new_sboxw | key_new_sboxw, 0);
    cyc();
    reset_n = 1;
    ack_log.delete();
  endtask
  task automatic chk_log(input string name, input int exp[], input int n);
    chk({name, "_len"}, ack_log.size() >= n, 1);
    for (int i = 0; i < n && i < ack_log.size(); i++) chk(name, ack_log[i], exp[i]);
  endtask
  initial begin
    logic [7:0]  wv[4];
    logic [31:0] rv[4];
    logic [7:0]  b;
    wv = '{8'h00, 8'h11, 8'h22, 8'h33};
    rv = '{32'h63636363, 32'h82828282, 32'h93939393, 32'hc3c3c3c3};
    // single encipher word after reset: one arbitration cycle, then result
    do_reset();
    enc_req = 1;
    enc_sboxw = 32'h00010203;
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_ack", enc_ack, 0);
    cyc();
    @(negedge clk);
`ifdef AES_SBOX_ARB_PIPE_EN
    chk("t1_latency", enc_ack, 0);
    cyc();
    @(negedge clk);
`endif
    chk("t1_ack", enc_ack, 1);
    chk("t1_data", enc_new_sboxw, 32'h637c777b);
    cyc();
    enc_req = 0;
    repeat (2) cyc();
    // tie after reset goes to encipher; release hands over without an idle cycle
    do_reset();
    {enc_req, key_req} = 2'b11;
    enc_sboxw = 32'h40414243;
    key_sboxw = 32'h11223344;
    repeat (3) cyc();
    enc_req = 0;
`ifndef AES_SBOX_ARB_PIPE_EN
    @(negedge clk);
    chk("t2_gap_busy", busy, 1);
    chk("t2_gap_acks", {enc_ack, key_ack}, 0);
    cyc();
    @(negedge clk);
    chk("t2_key_ack", key_ack, 1);
    chk("t2_key_data", key_new_sboxw, 32'h8293c31b);
`endif
    repeat (3) cyc();
    chk_log("t2_order", '{1, 1, 2}, 3);
    key_req = 0;
    repeat (2) cyc();
    // both requesting continuously: bursts of MAX_BURST alternate
    do_reset();
    {enc_req, key_req} = 2'b11;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 16 + 1);
      enc_sboxw = {4{b}};
      key_sboxw = {4{~b}};
      cyc();
    end
    chk_log("t3_burst", '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1}, 12);
    // lock keeps encipher past the burst limit
    do_reset();
    {enc_req, enc_lock, key_req} = 3'b111;
    enc_sboxw = 32'hdeadbeef;
    key_sboxw = 32'h0badf00d;
    repeat (9) cyc();
    {enc_req, enc_lock} = 2'b00;
    repeat (4) cyc();
    chk_log("t4_lock", '{1, 1, 1, 1, 1, 1, 1, 1, 2}, 9);
    // async reset in the middle of a key burst
    do_reset();
    key_req = 1;
    key_sboxw = 32'h01020304;
    repeat (2) cyc();
    key_sboxw = 32'h05060708;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ack", key_ack, 0);
    chk("t5_sboxw", sboxw, 0);
    chk("t5_new", key_new_sboxw, 0);
    @(negedge clk);
    cyc();
    reset_n = 1;
    enc_req = 1;
    enc_sboxw = 32'h10203040;
    @(negedge clk);
    chk("t5_idle", busy, 0);
    cyc();
    @(negedge clk);
    chk("t5_enc_sboxw", sboxw, 32'h10203040);
    chk("t5_enc_first", busy, 1);
    cyc();
    {enc_req, key_req} = 2'b00;
    repeat (3) cyc();
    // back-to-back encipher words
    do_reset();
    enc_req = 1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      enc_sboxw = {4{wv[k]}};
      @(negedge clk);
`ifdef AES_SBOX_ARB_PIPE_EN
      chk("t6_ack", enc_ack, k > 0);
      if (k > 0) chk("t6_data", enc_new_sboxw, rv[k-1]);
`else
      chk("t6_ack", enc_ack, 1);
      chk("t6_data", enc_new_sboxw, rv[k]);
`endif
      cyc();
    end
    enc_req = 0;
`ifdef AES_SBOX_ARB_PIPE_EN
    @(negedge clk);
    chk("t6_ack", enc_ack, 1);
    chk("t6_data", enc_new_sboxw, rv[3]);
`endif
    repeat (3) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
